// File: rtl/mem_trace_buffer.sv
// Capture buffer for PDP-8 bus transactions (IF/DR/DW) drained over a FWFT valid/ready port.
// Optional per-entry cycle timestamps are built when TRACE_TIMESTAMP_EN is defined.
module mem_trace_buffer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 64,
    parameter int TS_W   = 16
) (
    input  logic                       clk,
    input  logic                       btnCpuReset,
    input  logic                       run,
    input  logic                       mem_finished,
    input  logic                       read_enable,
    input  logic                       write_enable,
    input  logic                       read_type,
    input  logic [ADDR_W-1:0]          address,
    input  logic [DATA_W-1:0]          read_data,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       wrap_mode,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_kind,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    output logic [TS_W-1:0]            out_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [1:0]                 state_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'b00, CAPTURE = 2'b01, HOLD = 2'b10} state_t;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t          state_q, state_d;
    logic            mf_q, run_q;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            evt, push_req, pop, empty, full;
    logic            wr_en, rd_inc, cnt_inc, cnt_dec, ovf_set, drop;
    entry_t          new_ent;
    entry_t          mem [DEPTH];

    assign evt      = mem_finished & ~mf_q;
    assign push_req = evt & (state_q == CAPTURE);
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop      = ~empty & out_ready;

    // Both or neither enables is a malformed bus cycle: logged as ERR with zero data.
    always_comb begin
        new_ent.addr = address;
        new_ent.kind = 2'b11;
        new_ent.data = '0;
        if (read_enable && !write_enable) begin
            new_ent.kind = read_type ? 2'b01 : 2'b00;
            new_ent.data = read_data;
        end else if (write_enable && !read_enable) begin
            new_ent.kind = 2'b10;
            new_ent.data = write_data;
        end
    end

    // A simultaneous pop frees the slot, so a full buffer never loses data in that case.
    always_comb begin
        wr_en   = 1'b0;
        rd_inc  = 1'b0;
        cnt_inc = 1'b0;
        cnt_dec = 1'b0;
        ovf_set = 1'b0;
        drop    = 1'b0;
        if (!clear) begin
            if (push_req) begin
                if (pop) begin
                    wr_en  = 1'b1;
                    rd_inc = 1'b1;
                end else if (!full) begin
                    wr_en   = 1'b1;
                    cnt_inc = 1'b1;
                end else if (wrap_mode) begin
                    wr_en   = 1'b1;
                    rd_inc  = 1'b1;
                    ovf_set = 1'b1;
                end else begin
                    drop    = 1'b1;
                    ovf_set = 1'b1;
                end
            end else if (pop) begin
                rd_inc  = 1'b1;
                cnt_dec = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run && !run_q) state_d = CAPTURE;
            CAPTURE: if ((!run && run_q) || drop) state_d = HOLD;
            HOLD:    if (empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state_q  <= IDLE;
            mf_q     <= 1'b0;
            run_q    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            mf_q    <= mem_finished;
            run_q   <= run;
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
                if (rd_inc)  rd_ptr <= rd_ptr + 1'b1;
                if (cnt_inc) count  <= count + 1'b1;
                else if (cnt_dec) count <= count - 1'b1;
                if (ovf_set) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= new_ent;
    end

    assign out_valid = ~empty;
    assign out_kind  = empty ? 2'b00 : mem[rd_ptr].kind;
    assign out_addr  = empty ? '0 : mem[rd_ptr].addr;
    assign out_data  = empty ? '0 : mem[rd_ptr].data;
    assign state_o   = state_q;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_mem [DEPTH];

    // Counts only while capturing, restarts at each capture start, sticks at all-ones.
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            ts_cnt <= '0;
        end else if (clear || (state_q == IDLE && state_d == CAPTURE)) begin
            ts_cnt <= '0;
        end else if (state_q == CAPTURE && ts_cnt != '1) begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) ts_mem[wr_ptr] <= ts_cnt;
    end

    assign out_ts = empty ? '0 : ts_mem[rd_ptr];
`else
    assign out_ts = '0;
`endif
endmodule

// File: tb/tb_mem_trace_buffer.sv
// Scoreboard bench for mem_trace_buffer: expected entries are queued as events are driven
// and compared as the DUT pops them.
module tb_mem_trace_buffer;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        btnCpuReset;
    logic        run, mem_finished, read_enable, write_enable, read_type;
    logic [11:0] address, read_data, write_data;
    logic        wrap_mode, clear, out_valid, out_ready;
    logic [1:0]  out_kind;
    logic [11:0] out_addr, out_data;
    logic [15:0] out_ts;
    logic [6:0]  count;
    logic        overflow;
    logic [1:0]  state_o;

    typedef struct {
        logic [1:0]  k;
        logic [11:0] a;
        logic [11:0] d;
    } ent_t;

    ent_t q[$];
    bit   m_cap, m_ovf, lat_vld;
    int   total = 0;
    int   bad = 0;

    mem_trace_buffer #(.ADDR_W(12), .DATA_W(12), .DEPTH(DEPTH), .TS_W(16)) dut (
        .clk(clk), .btnCpuReset(btnCpuReset), .run(run), .mem_finished(mem_finished),
        .read_enable(read_enable), .write_enable(write_enable), .read_type(read_type),
        .address(address), .read_data(read_data), .write_data(write_data),
        .wrap_mode(wrap_mode), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_addr(out_addr), .out_data(out_data), .out_ts(out_ts),
        .count(count), .overflow(overflow), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_head();
        chk("valid", out_valid, 1);
        chk("kind", out_kind, q[0].k);
        chk("addr", out_addr, q[0].a);
        chk("data", out_data, q[0].d);
    endtask

    // k: 0 IF, 1 DR, 2 DW, 3 ERR (both enables); the unused data bus carries ~d
    task automatic send(input logic [1:0] k, input logic [11:0] a, input logic [11:0] d, input bit rdy);
        ent_t e;
        bit   popped;
        popped       = 0;
        read_enable  = (k != 2'd2);
        write_enable = (k == 2'd2 || k == 2'd3);
        read_type    = (k == 2'd1);
        address      = a;
        read_data    = (k == 2'd2) ? ~d : d;
        write_data   = (k == 2'd2) ? d : ~d;
        mem_finished = 1'b1;
        out_ready    = rdy;
        if (rdy && q.size() > 0) begin
            chk_head();
            void'(q.pop_front());
            popped = 1;
        end
        e.k = k;
        e.a = a;
        e.d = (k == 2'd3) ? 12'd0 : d;
        if (m_cap) begin
            if (popped || q.size() < DEPTH) q.push_back(e);
            else if (wrap_mode) begin
                void'(q.pop_front());
                q.push_back(e);
                m_ovf = 1;
            end else begin
                m_ovf = 1;
                m_cap = 0;
            end
        end
        @(negedge clk);
        lat_vld      = out_valid;
        mem_finished = 1'b0;
        out_ready    = 1'b0;
        @(negedge clk);
        chk("count", count, q.size());
        chk("ovf", overflow, m_ovf);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            chk_head();
            out_ready = 1'b1;
            @(negedge clk);
            void'(q.pop_front());
        end
        out_ready = 1'b0;
        chk("drain_cnt", count, q.size());
    endtask

    task automatic start_capture();
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        m_cap = 1;
        chk("st_cap", state_o, 2'b01);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        q.delete();
        m_ovf = 0;
        m_cap = 0;
    endtask

    initial begin
        btnCpuReset = 1'b0; run = 0; mem_finished = 0; read_enable = 0; write_enable = 0;
        read_type = 0; address = 0; read_data = 0; write_data = 0; wrap_mode = 0;
        clear = 0; out_ready = 0; m_cap = 0; m_ovf = 0; lat_vld = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_state", state_o, 0);
        chk("rst_kind", out_kind, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_data", out_data, 0);
        btnCpuReset = 1'b1;
        @(negedge clk);

        // basic IF/DR/DW, first one with out_ready=1 while empty (pop ignored)
        start_capture();
        send(2'd0, 12'o0200, 12'o7200, 1);
        chk("latency", lat_vld, 1);
        send(2'd1, 12'o0010, 12'o0042, 0);
        send(2'd2, 12'o0011, 12'o0043, 0);
        drain(3);
`ifndef TRACE_TIMESTAMP_EN
        chk("ts_absent", out_ts, 0);
`endif

        // mem_finished held high: one entry only
        read_enable = 1; write_enable = 0; read_type = 0; address = 12'o0500;
        read_data = 12'o1234; mem_finished = 1;
        repeat (5) @(negedge clk);
        mem_finished = 0;
        @(negedge clk);
        q.push_back('{k: 2'd0, a: 12'o0500, d: 12'o1234});
        chk("held_cnt", count, 1);
        drain(1);

        // stop-on-full
        wrap_mode = 0;
        for (int i = 1; i <= 70; i++) send(2'd0, 12'(i), 12'(i + 1000), 0);
        chk("nw_cnt", count, 64);
        chk("nw_ovf", overflow, 1);
        chk("nw_state", state_o, 2'b10);
        chk("nw_head", out_addr, 1);
        drain(64);
        @(negedge clk);
        chk("nw_idle", state_o, 2'b00);
        chk("nw_valid", out_valid, 0);
        do_clear();
        chk("clr_ovf", overflow, 0);

        // wrap mode
        start_capture();
        wrap_mode = 1;
        for (int i = 1; i <= 70; i++) send(2'd1, 12'(100 + i), 12'(i), 0);
        chk("w_cnt", count, 64);
        chk("w_ovf", overflow, 1);
        chk("w_state", state_o, 2'b01);
        chk("w_head", out_addr, 107);
        do_clear();
        chk("clr_state", state_o, 2'b00);

        // full with concurrent pop: no loss, no overflow; then drain in HOLD
        start_capture();
        wrap_mode = 0;
        for (int i = 0; i < 64; i++) send(2'd2, 12'(200 + i), 12'(i * 3), 0);
        send(2'd0, 12'd999, 12'd77, 1);
        chk("fp_cnt", count, 64);
        chk("fp_ovf", overflow, 0);
        run = 0;
        m_cap = 0;
        @(negedge clk);
        chk("fp_hold", state_o, 2'b10);
        drain(64);
        @(negedge clk);
        chk("fp_idle", state_o, 2'b00);
        chk("fp_valid", out_valid, 0);

        // ERR kind, then clear coincident with an event
        start_capture();
        send(2'd3, 12'o0777, 12'o5555, 0);
        chk("err_ovf", overflow, 0);
        drain(1);
        read_enable = 1; write_enable = 0; mem_finished = 1; clear = 1;
        @(negedge clk);
        mem_finished = 0; clear = 0;
        q.delete(); m_cap = 0;
        chk("clrev_cnt", count, 0);
        chk("clrev_state", state_o, 2'b00);
        chk("clrev_valid", out_valid, 0);

`ifdef TRACE_TIMESTAMP_EN
        begin
            logic [15:0] t0;
            start_capture();
            send(2'd0, 12'd1, 12'd1, 0);
            repeat (8) @(negedge clk);
            send(2'd0, 12'd2, 12'd2, 0);
            t0 = out_ts;
            drain(1);
            chk("ts_diff", 32'(out_ts - t0), 10);
            drain(1);
            do_clear();
        end
`endif

        // async reset mid-capture
        start_capture();
        send(2'd0, 12'd5, 12'd6, 0);
        send(2'd1, 12'd7, 12'd8, 0);
        #2 btnCpuReset = 1'b0;
        #1;
        chk("ar_cnt", count, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_state", state_o, 0);
        @(negedge clk);
        btnCpuReset = 1'b1;
        q.delete(); m_cap = 0;
        @(negedge clk);
        chk("ar_after", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_trace_buffer.md
Name: mem_trace_buffer

Overview:
- Synthesizable capture buffer for PDP-8 bus transactions: instruction fetch (IF), data read (DR) and data write (DW).
- Sits beside Top's bus and snoops each memory-completion pulse, so an on-board or bench reader can drain the trace through a valid/ready port without file I/O.
- Parametrised successor to the fixed 12-bit text trace: configurable width and depth, wrap or stop-on-full mode, and an overflow/error flag.

Parameters:
ADDR_W, 12, bus address width
DATA_W, 12, bus data width
DEPTH, 64, entries; power of 2, minimum 4
TS_W, 16, timestamp width (used only with TRACE_TIMESTAMP_EN)

Ports:
clk  in  1  system clock; all flops on posedge
btnCpuReset  in  1  reset, asynchronous, active-low
run  in  1  capture enable (CPU running, same meaning as led[12])
mem_finished  in  1  memory-done strobe; may stay high for several cycles
read_enable  in  1  bus read qualifier
write_enable  in  1  bus write qualifier
read_type  in  1  1 = data read, 0 = instruction fetch
address  in  ADDR_W  bus address
read_data  in  DATA_W  bus read data
write_data  in  DATA_W  bus write data
wrap_mode  in  1  1 = overwrite oldest entry when full, 0 = stop when full
clear  in  1  synchronous flush
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_kind  out  2  00 IF, 01 DR, 10 DW, 11 ERR
out_addr  out  ADDR_W  head entry address
out_data  out  DATA_W  head entry data
out_ts  out  TS_W  head entry timestamp (0 when feature absent)
count  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  sticky: an entry was lost or overwritten
state_o  out  2  00 IDLE, 01 CAPTURE, 10 HOLD

Behaviour:
- Reset (btnCpuReset=0, async): pointers=0, count=0, overflow=0, state=IDLE, out_valid=0, out_kind/addr/data/ts=0, edge-detect flop=0.
- Event detection:
  - An event is mem_finished=1 this cycle with the registered prior value 0.
  - Events count only in state CAPTURE.
- Kind encoding:
  - read_enable & ~write_enable: DR when read_type=1, IF when read_type=0.
  - write_enable & ~read_enable: DW.
  - Neither or both enables: ERR, and overflow is NOT set.
- Data field: read_data for IF/DR; write_data for DW; 0 for ERR.
- Latency: event in cycle N is written at the end of N; out_valid rises in N+1 if the buffer was empty.
- Output port is first-word-fall-through: out_* show the head entry whenever count>0.
- Pop: occurs when out_valid & out_ready at the clock edge; head advances. Pops are legal in every state.
- State machine:
  - IDLE -> CAPTURE on a rising edge of run.
  - CAPTURE -> HOLD when run falls.
  - CAPTURE -> HOLD on a push attempt with count=DEPTH, wrap_mode=0 and no simultaneous pop. The entry is dropped and overflow is set.
  - HOLD -> IDLE when count reaches 0.
  - A run rise while in HOLD is ignored.
- Full with wrap_mode=1 and no pop: the entry is written, the oldest entry is discarded (rd_ptr++), count stays DEPTH and overflow is set.
- Push and pop in the same cycle: count is unchanged, including when full; no overflow.
- Pop and push when empty: the push is captured and the pop is ignored (out_valid was 0).
- Pointers wrap modulo DEPTH.
- count ranges 0..DEPTH and never exceeds DEPTH.
- clear has priority over push and pop: pointers, count and overflow go to 0, state goes to IDLE, and the timestamp counter is cleared.
- Reset asserted mid-capture: all state is lost immediately; no partial entry is retained.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A TS_W free-running cycle counter runs in CAPTURE only and saturates at all-ones.
  - The counter resets to 0 on IDLE->CAPTURE.
  - Each entry stores the counter value of its event cycle, presented on out_ts.
- Undefined: no counter and no storage; out_ts is tied to 0.

Test Plan:
- Reset, raise run, issue 3 mem_finished pulses (IF 0200/7200, DR 0010/0042, DW 0011/0043) -> entries kinds 00,01,10 with those addr/data; count=3; out_valid one cycle after the first pulse.
- mem_finished held high 5 cycles -> exactly 1 entry captured.
- wrap_mode=0, DEPTH=64, 70 events, no pops -> count=64, overflow=1, state=HOLD, head address = that of event 1.
- wrap_mode=1, 70 events -> count=64, overflow=1, state=CAPTURE, head address = that of event 7.
- Full buffer with out_ready=1 during an event -> count stays 64, overflow=0; after run falls, drain 64 entries -> state IDLE, out_valid=0.
- Event with read_enable=write_enable=1 -> kind 11, data 0; then assert clear in the same cycle as an event -> count=0, state=IDLE. With TRACE_TIMESTAMP_EN, events spaced 10 cycles -> out_ts differs by 10.
